// File: rtl/mm_sched_pkg.sv
// ============================================================================
// Module   : mm_sched_pkg
// Brief    : Shared types and default widths for the matrix-multiply tile
//            scheduler (state encoding, tile instruction record).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mm_sched_pkg;

  // Default geometry; the scheduler's parameters take these as defaults.
  localparam int unsigned MM_N         = 4;
  localparam int unsigned MM_ADDR_BITS = 64;
  localparam int unsigned MM_MAX_LEN   = 4096;
  localparam int unsigned MM_CNT_BITS  = $clog2(MM_MAX_LEN + 1);
  localparam int unsigned MM_REP_BITS  = $clog2(MM_MAX_LEN / MM_N + 1);

  // Scheduler sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_A = 2'd1,
    ISSUE_B = 2'd2,
    DONE    = 2'd3
  } sched_state_e;

  // One memory-buffer tile instruction at the default widths.
  typedef struct packed {
    logic [MM_ADDR_BITS-1:0] address;
    logic [MM_CNT_BITS-1:0]  length;
    logic [MM_REP_BITS-1:0]  repeats;
  } mm_instr_t;

endpackage

`default_nettype wire

// File: rtl/mm_tile_addr_gen.sv
// ============================================================================
// Module   : mm_tile_addr_gen
// Brief    : Tile pointer and index counter. Loads a base address, then on
//            each step either advances the pointer by a fixed stride or, after
//            the last index, wraps both the index and the pointer to base.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mm_tile_addr_gen #(
  parameter int unsigned ADDR_BITS = 64,
  parameter int unsigned IDX_BITS  = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [ADDR_BITS-1:0] base_i,
  input  logic [ADDR_BITS-1:0] stride_i,
  input  logic [IDX_BITS-1:0]  last_idx_i,
  output logic [ADDR_BITS-1:0] ptr_o,
  output logic [IDX_BITS-1:0]  idx_o,
  output logic                 last_o
);

  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [ADDR_BITS-1:0] ptr_q,  ptr_d;
  logic [IDX_BITS-1:0]  idx_q,  idx_d;

  assign last_o = (idx_q == last_idx_i);
  assign ptr_o  = ptr_q;
  assign idx_o  = idx_q;

  // Next pointer/index: load wins over step; stepping past the last index wraps to base.
  always_comb begin
    base_d = base_q;
    ptr_d  = ptr_q;
    idx_d  = idx_q;
    if (load_i) begin
      base_d = base_i;
      ptr_d  = base_i;
      idx_d  = '0;
    end else if (step_i) begin
      if (last_o) begin
        idx_d = '0;
        ptr_d = base_q;
      end else begin
        idx_d = idx_q + IDX_BITS'(1);
        ptr_d = ptr_q + stride_i;
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= '0;
      ptr_q  <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mm_tile_scheduler.sv
// ============================================================================
// Module   : mm_tile_scheduler
// Brief    : Sequences C = A * B as tile instructions to the A-side and B-side
//            memory buffers: one A instruction per row-tile (repeat = column
//            tiles) followed by one B instruction per column-tile, with the
//            output tile coordinate published alongside each B instruction.
// Options  : MM_SCHED_PERF_EN adds saturating A/B stall-cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mm_tile_scheduler
  import mm_sched_pkg::*;
#(
  parameter int unsigned N                    = MM_N,
  parameter int unsigned MEMORY_ADDRESS_BITS  = MM_ADDR_BITS,
  parameter int unsigned MAX_MATRIX_LENGTH    = MM_MAX_LEN,
  parameter int unsigned COUNTER_BITS         = $clog2(MAX_MATRIX_LENGTH + 1),
  parameter int unsigned REPEATS_COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH / N + 1)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]  cmd_base_a,
  input  logic [MEMORY_ADDRESS_BITS-1:0]  cmd_base_b,
  input  logic [COUNTER_BITS-1:0]         cmd_rows,
  input  logic [COUNTER_BITS-1:0]         cmd_cols,
  input  logic [COUNTER_BITS-1:0]         cmd_k,
  output logic                            a_instr_valid,
  input  logic                            a_instr_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]  a_address,
  output logic [COUNTER_BITS-1:0]         a_length,
  output logic [REPEATS_COUNTER_BITS-1:0] a_repeats,
  output logic                            b_instr_valid,
  input  logic                            b_instr_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]  b_address,
  output logic [COUNTER_BITS-1:0]         b_length,
  output logic [REPEATS_COUNTER_BITS-1:0] b_repeats,
  output logic [REPEATS_COUNTER_BITS-1:0] tile_row,
  output logic [REPEATS_COUNTER_BITS-1:0] tile_col,
`ifdef MM_SCHED_PERF_EN
  output logic [31:0]                     perf_a_stall_cycles,
  output logic [31:0]                     perf_b_stall_cycles,
`endif
  output logic                            busy,
  output logic                            done,
  output logic                            cmd_error
);

  localparam int unsigned N_LOG2 = $clog2(N);

  sched_state_e state_q, state_d;

  logic [COUNTER_BITS-1:0]         k_q;
  logic [REPEATS_COUNTER_BITS-1:0] row_tiles_q, col_tiles_q;
  logic [MEMORY_ADDRESS_BITS-1:0]  stride_q;
  logic                            err_q, err_d;

  logic                            load;
  logic                            a_step, b_step;
  logic                            a_last, b_last;
  logic                            cmd_ok;

  logic [REPEATS_COUNTER_BITS-1:0] rows_tiles_w, cols_tiles_w;
  logic [MEMORY_ADDRESS_BITS-1:0]  stride_w;
  logic                            rows_aligned, cols_aligned;

  // Divide-by-N and stride product are only evaluated at command accept.
  if ((32'd1 << N_LOG2) == N) begin : g_div_shift
    assign rows_tiles_w = REPEATS_COUNTER_BITS'(cmd_rows >> N_LOG2);
    assign cols_tiles_w = REPEATS_COUNTER_BITS'(cmd_cols >> N_LOG2);
    assign rows_aligned = ((cmd_rows & COUNTER_BITS'(N - 1)) == '0);
    assign cols_aligned = ((cmd_cols & COUNTER_BITS'(N - 1)) == '0);
    assign stride_w     = MEMORY_ADDRESS_BITS'(cmd_k) << N_LOG2;
  end else begin : g_div_const
    assign rows_tiles_w = REPEATS_COUNTER_BITS'(cmd_rows / COUNTER_BITS'(N));
    assign cols_tiles_w = REPEATS_COUNTER_BITS'(cmd_cols / COUNTER_BITS'(N));
    assign rows_aligned = ((cmd_rows % COUNTER_BITS'(N)) == '0);
    assign cols_aligned = ((cmd_cols % COUNTER_BITS'(N)) == '0);
    assign stride_w     = MEMORY_ADDRESS_BITS'(cmd_k) * MEMORY_ADDRESS_BITS'(N);
  end

  assign cmd_ok = (cmd_rows != '0) && (cmd_cols != '0) && (cmd_k != '0) &&
                  rows_aligned && cols_aligned &&
                  (32'(cmd_rows) <= MAX_MATRIX_LENGTH) &&
                  (32'(cmd_cols) <= MAX_MATRIX_LENGTH) &&
                  (32'(cmd_k)    <= MAX_MATRIX_LENGTH);

  // Next-state and control strobes; A walks row-tiles, B walks column-tiles.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    load    = 1'b0;
    a_step  = 1'b0;
    b_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_ok) begin
            load    = 1'b1;
            state_d = ISSUE_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE_A: begin
        if (a_instr_ready) state_d = ISSUE_B;
      end
      ISSUE_B: begin
        if (b_instr_ready) begin
          b_step = 1'b1;
          if (b_last) begin
            // Row finished: the A pointer/row index advance here, which is
            // where the next A instruction (if any) first needs them.
            a_step  = 1'b1;
            state_d = a_last ? DONE : ISSUE_A;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and error pulse register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Command fields latched once at accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q         <= '0;
      row_tiles_q <= '0;
      col_tiles_q <= '0;
      stride_q    <= '0;
    end else if (load) begin
      k_q         <= cmd_k;
      row_tiles_q <= rows_tiles_w;
      col_tiles_q <= cols_tiles_w;
      stride_q    <= stride_w;
    end
  end

  mm_tile_addr_gen #(
    .ADDR_BITS (MEMORY_ADDRESS_BITS),
    .IDX_BITS  (REPEATS_COUNTER_BITS)
  ) u_a_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .step_i     (a_step),
    .base_i     (cmd_base_a),
    .stride_i   (stride_q),
    .last_idx_i (row_tiles_q - REPEATS_COUNTER_BITS'(1)),
    .ptr_o      (a_address),
    .idx_o      (tile_row),
    .last_o     (a_last)
  );

  mm_tile_addr_gen #(
    .ADDR_BITS (MEMORY_ADDRESS_BITS),
    .IDX_BITS  (REPEATS_COUNTER_BITS)
  ) u_b_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .step_i     (b_step),
    .base_i     (cmd_base_b),
    .stride_i   (stride_q),
    .last_idx_i (col_tiles_q - REPEATS_COUNTER_BITS'(1)),
    .ptr_o      (b_address),
    .idx_o      (tile_col),
    .last_o     (b_last)
  );

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign cmd_error     = err_q;
  assign a_instr_valid = (state_q == ISSUE_A);
  assign b_instr_valid = (state_q == ISSUE_B);
  assign a_length      = k_q;
  assign a_repeats     = col_tiles_q;
  assign b_length      = k_q;
  assign b_repeats     = REPEATS_COUNTER_BITS'(1);

`ifdef MM_SCHED_PERF_EN
  logic [31:0] perf_a_q, perf_b_q;

  // Saturating back-pressure counters, restarted by each accepted command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_a_q <= '0;
      perf_b_q <= '0;
    end else if (load) begin
      perf_a_q <= '0;
      perf_b_q <= '0;
    end else begin
      if (a_instr_valid && !a_instr_ready && (perf_a_q != '1)) perf_a_q <= perf_a_q + 32'd1;
      if (b_instr_valid && !b_instr_ready && (perf_b_q != '1)) perf_b_q <= perf_b_q + 32'd1;
    end
  end

  assign perf_a_stall_cycles = perf_a_q;
  assign perf_b_stall_cycles = perf_b_q;
`endif

endmodule

`default_nettype wire
